// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and helpers for the CORDIC datapath
package cordic_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_NOP = 2'd2,
        ALU_DIR = 2'd3
    } alu_op_t;

    localparam int DEFAULT_WORD_WIDTH = 16;

    // Largest positive two's-complement value of width w (w up to 31)
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Most negative two's-complement value of width w (w up to 31)
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/ars_shifter.sv
// rtl/ars_shifter.sv - combinational arithmetic right barrel shifter
module ars_shifter #(
    parameter int WORD_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic signed [WORD_WIDTH-1:0]  din,
    input  logic        [SHIFT_WIDTH-1:0] shamt,
    output logic signed [WORD_WIDTH-1:0]  dout
);

    // Sign-filling shift; a shift of WORD_WIDTH-1 leaves only sign copies
    always_comb begin
        dout = din >>> shamt;
    end

endmodule

// File: rtl/cordic_alu_pipe.sv
// rtl/cordic_alu_pipe.sv - two-stage shift/add ALU with valid/ready flow control
module cordic_alu_pipe
    import cordic_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int SHIFT_WIDTH = 4,
    parameter int SATURATE    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   alu_op,
    input  logic                         dir,
    input  logic [SHIFT_WIDTH-1:0]       shamt,
    input  logic signed [WORD_WIDTH-1:0] A,
    input  logic signed [WORD_WIDTH-1:0] B,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [WORD_WIDTH-1:0] alu_out,
    output logic                         overflow,
    output logic                         zero,
    output logic                         negative
);

    localparam logic signed [WORD_WIDTH-1:0] MAX_VAL = WORD_WIDTH'(sat_max(WORD_WIDTH));
    localparam logic signed [WORD_WIDTH-1:0] MIN_VAL = WORD_WIDTH'(sat_min(WORD_WIDTH));

    logic                         s1_valid;
    logic signed [WORD_WIDTH-1:0] s1_a;
    logic signed [WORD_WIDTH-1:0] s1_b;
    alu_op_t                      s1_op;
    logic                         s1_dir;

    logic                         s1_en;
    logic                         s2_en;
    logic signed [WORD_WIDTH-1:0] b_shifted;

    logic signed [WORD_WIDTH:0]   a_ext;
    logic signed [WORD_WIDTH:0]   b_ext;
    logic signed [WORD_WIDTH:0]   sum;
    logic                         sum_ovf;
    logic signed [WORD_WIDTH-1:0] result;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    ars_shifter #(
        .WORD_WIDTH  (WORD_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_shifter (
        .din   (B),
        .shamt (shamt),
        .dout  (b_shifted)
    );

    // Stage 1: capture A, the pre-shifted B and the operation
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= ALU_NOP;
            s1_dir   <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= A;
                s1_b   <= b_shifted;
                s1_op  <= alu_op_t'(alu_op);
                s1_dir <= dir;
            end
        end
    end

    // One extra bit of headroom so SUB of the most negative B' never wraps
    always_comb begin
        a_ext = {s1_a[WORD_WIDTH-1], s1_a};
        b_ext = {s1_b[WORD_WIDTH-1], s1_b};
        case (s1_op)
            ALU_ADD: sum = a_ext + b_ext;
            ALU_SUB: sum = a_ext - b_ext;
            ALU_DIR: sum = s1_dir ? (a_ext + b_ext) : (a_ext - b_ext);
            default: sum = a_ext;
        endcase
        sum_ovf = sum[WORD_WIDTH] ^ sum[WORD_WIDTH-1];
        if (sum_ovf && (SATURATE != 0)) begin
            result = sum[WORD_WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            result = sum[WORD_WIDTH-1:0];
        end
    end

    // Stage 2: register the result and flags; held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_out   <= '0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                alu_out  <= result;
                overflow <= sum_ovf;
                zero     <= (result == '0);
                negative <= result[WORD_WIDTH-1];
            end
        end
    end

endmodule
